// File: rtl/window_scan_controller.sv
// Serpentine 3x3 window sequencer: issues pixel reads and buffer shifts, then
// hands each completed window to the Sobel stage over a valid/ack handshake.
module window_scan_controller #(
    parameter int IMG_WIDTH  = 16,
    parameter int IMG_HEIGHT = 16,
    parameter int ADDR_W     = 16,
    parameter int COORD_W    = 8
) (
    input  logic               clk,
    input  logic               n_rst,
    input  logic               start,
    input  logic               read_done,
    input  logic               shift_done,
    input  logic               win_ack,
    output logic               start_read,
    output logic [ADDR_W-1:0]  read_addr,
    output logic [3:0]         read_slot,
    output logic               start_shift,
    output logic [1:0]         shift_direc,
    output logic               win_valid,
    output logic [COORD_W-1:0] center_x,
    output logic [COORD_W-1:0] center_y,
    output logic               busy,
    output logic               done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT_READ,
        S_WIN,
        S_SHIFT,
        S_COL_READ,
        S_DONE
    } state_e;

    typedef enum logic [1:0] {
        DIR_IDLE  = 2'b00,
        DIR_LEFT  = 2'b01,
        DIR_RIGHT = 2'b10,
        DIR_UP    = 2'b11
    } dir_e;

    typedef struct packed {
        logic [COORD_W-1:0] row;
        logic [COORD_W-1:0] col;
        logic [3:0]         slot;
    } rd_tgt_t;

    localparam logic [COORD_W-1:0] ONE   = COORD_W'(1);
    localparam logic [COORD_W-1:0] X_MAX = COORD_W'(IMG_WIDTH - 2);
    localparam logic [COORD_W-1:0] Y_MAX = COORD_W'(IMG_HEIGHT - 2);
    // An odd number of centre rows finishes the serpentine on the right edge.
    localparam logic [COORD_W-1:0] X_END = (((IMG_HEIGHT - 2) % 2) == 1) ? X_MAX : ONE;

    function automatic logic [ADDR_W-1:0] pix_addr(input rd_tgt_t t);
        return ADDR_W'(t.row) * ADDR_W'(IMG_WIDTH) + ADDR_W'(t.col);
    endfunction

    function automatic rd_tgt_t init_tgt(input logic [3:0] idx);
        rd_tgt_t t;
        t.slot = idx;
        if (idx >= 4'd6) begin
            t.row = COORD_W'(2);
            t.col = COORD_W'(idx - 4'd6);
        end else if (idx >= 4'd3) begin
            t.row = COORD_W'(1);
            t.col = COORD_W'(idx - 4'd3);
        end else begin
            t.row = '0;
            t.col = COORD_W'(idx);
        end
        return t;
    endfunction

    // Targets are relative to the old centre; the centre moves after the reads.
    function automatic rd_tgt_t col_tgt(input dir_e mv, input logic [COORD_W-1:0] cx,
                                        input logic [COORD_W-1:0] cy, input logic [1:0] k);
        rd_tgt_t t;
        case (mv)
            DIR_LEFT: begin
                t.row  = cy - ONE + COORD_W'(k);
                t.col  = cx + COORD_W'(2);
                t.slot = 4'd2 + 4'd3 * {2'b00, k};
            end
            DIR_RIGHT: begin
                t.row  = cy - ONE + COORD_W'(k);
                t.col  = cx - COORD_W'(2);
                t.slot = 4'd3 * {2'b00, k};
            end
            default: begin
                t.row  = cy + COORD_W'(2);
                t.col  = cx - ONE + COORD_W'(k);
                t.slot = 4'd6 + {2'b00, k};
            end
        endcase
        return t;
    endfunction

    state_e             state_q, state_d;
    dir_e               mv_q, mv_d;
    logic [3:0]         idx_q, idx_d;
    logic [COORD_W-1:0] cx_q, cx_d, cy_q, cy_d;
    logic               start_read_q, start_read_d;
    logic [ADDR_W-1:0]  read_addr_q, read_addr_d;
    logic [3:0]         read_slot_q, read_slot_d;
    logic               start_shift_q, start_shift_d;
    logic [1:0]         shift_direc_q, shift_direc_d;
    logic               win_valid_q, win_valid_d;
    logic               done_q, done_d;

    rd_tgt_t tgt;
    logic    issue_rd;
    dir_e    next_mv;
    logic    last_win;

    always_comb begin
        // NOTE: every _d starts from its _q, so no path through this block infers a latch.
        state_d       = state_q;
        mv_d          = mv_q;
        idx_d         = idx_q;
        cx_d          = cx_q;
        cy_d          = cy_q;
        start_read_d  = start_read_q;
        read_addr_d   = read_addr_q;
        read_slot_d   = read_slot_q;
        start_shift_d = start_shift_q;
        shift_direc_d = shift_direc_q;
        win_valid_d   = win_valid_q;
        done_d        = done_q;
        tgt           = '0;
        issue_rd      = 1'b0;

        if (cy_q[0] && cx_q < X_MAX) begin
            next_mv = DIR_LEFT;
        end else if (!cy_q[0] && cx_q > ONE) begin
            next_mv = DIR_RIGHT;
        end else begin
            next_mv = DIR_UP;
        end
        last_win = (cy_q == Y_MAX) && (cx_q == X_END);

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    cx_d     = ONE;
                    cy_d     = ONE;
                    idx_d    = '0;
                    tgt      = init_tgt(4'd0);
                    issue_rd = 1'b1;
                    state_d  = S_INIT_READ;
                end
            end
            S_INIT_READ: begin
                if (read_done) begin
                    start_read_d = 1'b0;
                    read_addr_d  = '0;
                    read_slot_d  = '0;
                    if (idx_q == 4'd8) begin
                        win_valid_d = 1'b1;
                        state_d     = S_WIN;
                    end else begin
                        idx_d    = idx_q + 4'd1;
                        tgt      = init_tgt(idx_q + 4'd1);
                        issue_rd = 1'b1;
                    end
                end
            end
            S_WIN: begin
                if (win_ack) begin
                    win_valid_d = 1'b0;
                    if (last_win) begin
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        mv_d          = next_mv;
                        start_shift_d = 1'b1;
                        shift_direc_d = next_mv;
                        state_d       = S_SHIFT;
                    end
                end
            end
            S_SHIFT: begin
                if (shift_done) begin
                    start_shift_d = 1'b0;
                    shift_direc_d = DIR_IDLE;
                    idx_d         = '0;
                    tgt           = col_tgt(mv_q, cx_q, cy_q, 2'd0);
                    issue_rd      = 1'b1;
                    state_d       = S_COL_READ;
                end
            end
            S_COL_READ: begin
                if (read_done) begin
                    start_read_d = 1'b0;
                    read_addr_d  = '0;
                    read_slot_d  = '0;
                    if (idx_q == 4'd2) begin
                        case (mv_q)
                            DIR_LEFT:  cx_d = cx_q + ONE;
                            DIR_RIGHT: cx_d = cx_q - ONE;
                            default:   cy_d = cy_q + ONE;
                        endcase
                        win_valid_d = 1'b1;
                        state_d     = S_WIN;
                    end else begin
                        idx_d    = idx_q + 4'd1;
                        tgt      = col_tgt(mv_q, cx_q, cy_q, idx_q[1:0] + 2'd1);
                        issue_rd = 1'b1;
                    end
                end
            end
            S_DONE: begin
                done_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (issue_rd) begin
            start_read_d = 1'b1;
            read_addr_d  = pix_addr(tgt);
            read_slot_d  = tgt.slot;
        end
    end

    // Centre outputs read 0 out of reset; a start pulse loads (1,1).
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q       <= S_IDLE;
            mv_q          <= DIR_IDLE;
            idx_q         <= '0;
            cx_q          <= '0;
            cy_q          <= '0;
            start_read_q  <= 1'b0;
            read_addr_q   <= '0;
            read_slot_q   <= '0;
            start_shift_q <= 1'b0;
            shift_direc_q <= DIR_IDLE;
            win_valid_q   <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            // NOTE: non-blocking updates so every flop samples the same pre-edge values.
            state_q       <= state_d;
            mv_q          <= mv_d;
            idx_q         <= idx_d;
            cx_q          <= cx_d;
            cy_q          <= cy_d;
            start_read_q  <= start_read_d;
            read_addr_q   <= read_addr_d;
            read_slot_q   <= read_slot_d;
            start_shift_q <= start_shift_d;
            shift_direc_q <= shift_direc_d;
            win_valid_q   <= win_valid_d;
            done_q        <= done_d;
        end
    end

    assign start_read  = start_read_q;
    assign read_addr   = read_addr_q;
    assign read_slot   = read_slot_q;
    assign start_shift = start_shift_q;
    assign shift_direc = shift_direc_q;
    assign win_valid   = win_valid_q;
    assign center_x    = cx_q;
    assign center_y    = cy_q;
    assign busy        = (state_q != S_IDLE);
    assign done        = done_q;

endmodule

// File: tb/tb_window_scan_controller.sv
// Bench for window_scan_controller: three frame sizes share handshake inputs and
// are checked against a set-difference model of the serpentine window walk.
module tb_window_scan_controller;

    typedef struct packed {
        logic        start_read;
        logic [15:0] read_addr;
        logic [3:0]  read_slot;
        logic        start_shift;
        logic [1:0]  shift_direc;
        logic        win_valid;
        logic [7:0]  center_x;
        logic [7:0]  center_y;
        logic        busy;
        logic        done;
    } obs_t;

    typedef enum int {EV_NONE, EV_READ, EV_SHIFT, EV_WIN} ev_kind_e;
    typedef struct {
        ev_kind_e kind;
        int       a;
        int       b;
    } ev_t;

    localparam int WS [3] = '{4, 3, 6};
    localparam int HS [3] = '{4, 3, 5};

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic [2:0] start_v = '0;
    logic       read_done = 1'b0;
    logic       shift_done = 1'b0;
    logic       win_ack = 1'b0;

    logic        sr   [3];
    logic [15:0] ra   [3];
    logic [3:0]  rs   [3];
    logic        ss   [3];
    logic [1:0]  sdir [3];
    logic        wv   [3];
    logic [7:0]  cx   [3];
    logic [7:0]  cy   [3];
    logic        bz   [3];
    logic        dn   [3];
    obs_t        obs  [3];

    int   checks = 0;
    int   failures = 0;
    ev_t  exp_q[$];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        window_scan_controller #(
            .IMG_WIDTH (WS[g]),
            .IMG_HEIGHT(HS[g]),
            .ADDR_W    (16),
            .COORD_W   (8)
        ) u_dut (
            .clk        (clk),
            .n_rst      (n_rst),
            .start      (start_v[g]),
            .read_done  (read_done),
            .shift_done (shift_done),
            .win_ack    (win_ack),
            .start_read (sr[g]),
            .read_addr  (ra[g]),
            .read_slot  (rs[g]),
            .start_shift(ss[g]),
            .shift_direc(sdir[g]),
            .win_valid  (wv[g]),
            .center_x   (cx[g]),
            .center_y   (cy[g]),
            .busy       (bz[g]),
            .done       (dn[g])
        );
        assign obs[g] = {sr[g], ra[g], rs[g], ss[g], sdir[g], wv[g], cx[g], cy[g], bz[g], dn[g]};
    end

    // Reference: walk the window centres, and for each step read exactly the
    // pixels of the new window that the previous window did not cover.
    task automatic build_frame(input int w, input int h);
        int  px = 0;
        int  py = 0;
        bit  first = 1'b1;
        exp_q.delete();
        for (int y = 1; y <= h - 2; y++) begin
            for (int i = 0; i < w - 2; i++) begin
                int x = ((y - 1) % 2 == 0) ? 1 + i : w - 2 - i;
                if (!first) begin
                    int dir = (y > py) ? 3 : (x > px) ? 1 : 2;
                    exp_q.push_back('{EV_SHIFT, dir, 0});
                end
                for (int s = 0; s < 9; s++) begin
                    int r = y - 1 + s / 3;
                    int c = x - 1 + s % 3;
                    if (first || r > py + 1 || r < py - 1 || c > px + 1 || c < px - 1)
                        exp_q.push_back('{EV_READ, r * w + c, s});
                end
                exp_q.push_back('{EV_WIN, x, y});
                px = x;
                py = y;
                first = 1'b0;
            end
        end
    endtask

    function automatic ev_t pop_exp();
        ev_t e;
        if (exp_q.size() > 0) e = exp_q.pop_front();
        else e = '{EV_NONE, -1, -1};
        return e;
    endfunction

    function automatic bit is_quiet(input obs_t x);
        return {x.start_read, x.read_addr, x.read_slot, x.start_shift, x.shift_direc,
                x.win_valid, x.busy, x.done} === '0;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_pulse(input int idx);
        start_v[idx] = 1'b1;
        step();
        start_v[idx] = 1'b0;
    endtask

    task automatic apply_reset();
        start_v    = '0;
        read_done  = 1'b0;
        shift_done = 1'b0;
        win_ack    = 1'b0;
        n_rst      = 1'b0;
        repeat (2) step();
        n_rst = 1'b1;
        step();
    endtask

    // Runs one frame on instance idx with bounded handshake delays, checking every
    // transfer against the model and every cycle for protocol rules.
    task automatic run_scan(input int idx, input int rd_max, input int sd_max,
                            input int ack_max, input bit fixed, input bit noisy);
        obs_t ob;
        obs_t prev;
        bit   rd_hold = 1'b0, sd_hold = 1'b0, wv_hold = 1'b0;
        bit   last_acked = 1'b0, saw_done = 1'b0, finished = 1'b0;
        int   waited = 0, target = 0, cycles = 0, lx = 1, ly = 1;
        ev_t  e;
        build_frame(WS[idx], HS[idx]);
        start_pulse(idx);
        while (cycles < 5000) begin
            ob = obs[idx];
            if (saw_done) begin
                checks++;
                if (ob.done !== 1'b0 || ob.busy !== 1'b0) begin
                    failures++;
                    $display("FAIL post_done dut%0d done=%b busy=%b want 0 0", idx, ob.done, ob.busy);
                end
                finished = 1'b1;
                break;
            end
            begin
                int ex, ey;
                bit ok;
                if (ob.win_valid && exp_q.size() > 0 && exp_q[0].kind == EV_WIN) begin
                    ex = exp_q[0].a;
                    ey = exp_q[0].b;
                end else begin
                    ex = lx;
                    ey = ly;
                end
                ok = (int'(ob.start_read) + int'(ob.start_shift) + int'(ob.win_valid) <= 1)
                     && (ob.start_shift || ob.shift_direc == 2'b00)
                     && ob.center_x == 8'(ex) && ob.center_y == 8'(ey)
                     && ob.done == last_acked && ob.busy == 1'b1;
                checks++;
                if (ok !== 1'b1) begin
                    failures++;
                    $display("FAIL protocol dut%0d cyc=%0d got sr=%b ss=%b wv=%b dir=%b c=(%0d,%0d) done=%b busy=%b want centre (%0d,%0d) done=%b busy=1",
                             idx, cycles, ob.start_read, ob.start_shift, ob.win_valid, ob.shift_direc,
                             ob.center_x, ob.center_y, ob.done, ob.busy, ex, ey, last_acked);
                end
            end
            if (last_acked) saw_done = 1'b1;
            if (rd_hold) begin
                checks++;
                if (ob.start_read !== 1'b1 || ob.read_addr !== prev.read_addr || ob.read_slot !== prev.read_slot) begin
                    failures++;
                    $display("FAIL read_hold dut%0d got sr=%b addr=%0d slot=%0d want 1 %0d %0d",
                             idx, ob.start_read, ob.read_addr, ob.read_slot, prev.read_addr, prev.read_slot);
                end
            end
            if (sd_hold) begin
                checks++;
                if (ob.start_shift !== 1'b1 || ob.shift_direc !== prev.shift_direc) begin
                    failures++;
                    $display("FAIL shift_hold dut%0d got ss=%b dir=%b want 1 %b",
                             idx, ob.start_shift, ob.shift_direc, prev.shift_direc);
                end
            end
            if (wv_hold) begin
                checks++;
                if (ob.win_valid !== 1'b1) begin
                    failures++;
                    $display("FAIL win_hold dut%0d got win_valid=%b want 1", idx, ob.win_valid);
                end
            end

            read_done    = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
            shift_done   = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
            win_ack      = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
            start_v[idx] = (ob.busy === 1'b1) && (cycles == 2 || (noisy && $urandom_range(0, 5) == 0));
            if (ob.start_read || ob.start_shift || ob.win_valid) begin
                int mx = ob.start_read ? rd_max : ob.start_shift ? sd_max : ack_max;
                bit go;
                if (waited == 0) target = fixed ? mx : int'($urandom_range(0, mx));
                go = (waited >= target);
                waited = go ? 0 : waited + 1;
                if (ob.start_read) read_done = go;
                else if (ob.start_shift) shift_done = go;
                else win_ack = go;
            end else begin
                waited = 0;
            end

            prev    = ob;
            rd_hold = ob.start_read && !read_done;
            sd_hold = ob.start_shift && !shift_done;
            wv_hold = ob.win_valid && !win_ack;
            if (ob.start_read && read_done) begin
                e = pop_exp();
                checks++;
                if (e.kind != EV_READ || ob.read_addr !== 16'(e.a) || ob.read_slot !== 4'(e.b)) begin
                    failures++;
                    $display("FAIL read_xfer dut%0d got addr=%0d slot=%0d want kind=%0d addr=%0d slot=%0d",
                             idx, ob.read_addr, ob.read_slot, e.kind, e.a, e.b);
                end
            end
            if (ob.start_shift && shift_done) begin
                e = pop_exp();
                checks++;
                if (e.kind != EV_SHIFT || ob.shift_direc !== 2'(e.a)) begin
                    failures++;
                    $display("FAIL shift_xfer dut%0d got dir=%b want kind=%0d dir=%0d",
                             idx, ob.shift_direc, e.kind, e.a);
                end
            end
            if (ob.win_valid && win_ack) begin
                e = pop_exp();
                checks++;
                if (e.kind != EV_WIN || ob.center_x !== 8'(e.a) || ob.center_y !== 8'(e.b)) begin
                    failures++;
                    $display("FAIL win_xfer dut%0d got centre=(%0d,%0d) want kind=%0d (%0d,%0d)",
                             idx, ob.center_x, ob.center_y, e.kind, e.a, e.b);
                end
                lx = e.a;
                ly = e.b;
                if (exp_q.size() == 0) last_acked = 1'b1;
            end
            step();
            cycles++;
        end
        if (!finished) begin
            checks++;
            failures++;
            $display("FAIL scan_timeout dut%0d cycles=%0d remaining_events=%0d want 0", idx, cycles, exp_q.size());
        end
        start_v    = '0;
        read_done  = 1'b0;
        shift_done = 1'b0;
        win_ack    = 1'b0;
        step();
    endtask

    task automatic test_reset();
        n_rst = 1'b0;
        repeat (2) step();
        for (int g = 0; g < 3; g++) begin
            checks++;
            if (!is_quiet(obs[g])) begin
                failures++;
                $display("FAIL reset_state dut%0d got=%h want all-zero controls", g, obs[g]);
            end
        end
        n_rst = 1'b1;
        repeat (2) step();
        for (int g = 0; g < 3; g++) begin
            checks++;
            if (!is_quiet(obs[g])) begin
                failures++;
                $display("FAIL idle_after_reset dut%0d got=%h want all-zero controls", g, obs[g]);
            end
        end
    endtask

    task automatic test_frame_4x4();
        run_scan(0, 0, 0, 0, 1'b1, 1'b0);
    endtask

    task automatic test_backpressure();
        start_pulse(0);
        checks++;
        if (obs[0].start_read !== 1'b1 || obs[0].read_addr !== 16'd0 || obs[0].read_slot !== 4'd0) begin
            failures++;
            $display("FAIL bp_first_read got sr=%b addr=%0d slot=%0d want 1 0 0",
                     obs[0].start_read, obs[0].read_addr, obs[0].read_slot);
        end
        read_done = 1'b1;
        step();
        checks++;
        if (obs[0].start_read !== 1'b1 || obs[0].read_addr !== 16'd1 || obs[0].read_slot !== 4'd1) begin
            failures++;
            $display("FAIL bp_second_read got sr=%b addr=%0d slot=%0d want 1 1 1",
                     obs[0].start_read, obs[0].read_addr, obs[0].read_slot);
        end
        step();
        read_done = 1'b0;
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (obs[0].start_read !== 1'b1 || obs[0].read_addr !== 16'd2 || obs[0].read_slot !== 4'd2) begin
                failures++;
                $display("FAIL bp_stall cyc=%0d got sr=%b addr=%0d slot=%0d want 1 2 2",
                         k, obs[0].start_read, obs[0].read_addr, obs[0].read_slot);
            end
            step();
        end
        read_done = 1'b1;
        step();
        read_done = 1'b0;
        checks++;
        if (obs[0].start_read !== 1'b1 || obs[0].read_addr !== 16'd4 || obs[0].read_slot !== 4'd3) begin
            failures++;
            $display("FAIL bp_next_read got sr=%b addr=%0d slot=%0d want 1 4 3",
                     obs[0].start_read, obs[0].read_addr, obs[0].read_slot);
        end
        apply_reset();
    endtask

    task automatic test_shift_stall();
        run_scan(0, 0, 3, 4, 1'b1, 1'b0);
    endtask

    task automatic test_reset_mid_col();
        bit prev_ss = 1'b0;
        int guard = 0;
        start_pulse(0);
        read_done  = 1'b1;
        shift_done = 1'b1;
        win_ack    = 1'b1;
        while (!(prev_ss && obs[0].start_read) && guard < 100) begin
            prev_ss = obs[0].start_shift;
            step();
            guard++;
        end
        checks++;
        if (guard >= 100) begin
            failures++;
            $display("FAIL reach_col_read waited=%0d cycles want < 100", guard);
        end else begin
            #2;
            n_rst = 1'b0;
            #1;
            checks++;
            if (!is_quiet(obs[0])) begin
                failures++;
                $display("FAIL async_abort got=%h want all-zero controls", obs[0]);
            end
        end
        read_done  = 1'b0;
        shift_done = 1'b0;
        win_ack    = 1'b0;
        step();
        n_rst = 1'b1;
        step();
        run_scan(0, 1, 1, 1, 1'b0, 1'b0);
    endtask

    task automatic test_degenerate_3x3();
        run_scan(1, 0, 0, 0, 1'b1, 1'b0);
        run_scan(1, 3, 3, 3, 1'b0, 1'b1);
    endtask

    task automatic test_random();
        run_scan(2, 3, 3, 3, 1'b0, 1'b1);
        run_scan(0, 2, 4, 3, 1'b0, 1'b1);
        run_scan(2, 0, 0, 0, 1'b1, 1'b0);
    endtask

    initial begin
        test_reset();
        test_frame_4x4();
        test_backpressure();
        test_shift_stall();
        test_reset_mid_col();
        test_degenerate_3x3();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL global_timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "global timeout");
    end

endmodule
